// File: rtl/tmds_decoder.sv
// tmds_decoder: single-lane TMDS receive decoder with control-token word alignment.
// Ports: clk_pix pixel clock; rst_n synchronous active-low reset;
//        raw[9:0] unaligned deserializer word (bit 0 earliest);
//        data[7:0] video byte, ctrl[1:0] control code, de (1 = data valid);
//        locked alignment achieved; offset[3:0] bit-slip position 0..9;
//        err_cnt[15:0] saturating lock-loss count, present only with TMDS_DEC_STATS_EN.
module tmds_decoder #(
    parameter int TOKEN_RUN     = 8,
    parameter int SEARCH_CYCLES = 1024,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic [9:0]  raw,
    output logic [7:0]  data,
    output logic [1:0]  ctrl,
    output logic        de,
    output logic        locked,
    output logic [3:0]  offset
`ifdef TMDS_DEC_STATS_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t      state_q, state_d;
    logic [9:0]  r1_q, r2_q, w;
    logic [7:0]  run_q, run_d, data_q, data_d, q, d;
    logic [15:0] dwell_q, dwell_d, gap_q, gap_d;
    logic [3:0]  offset_q, offset_d;
    logic [1:0]  ctrl_q, ctrl_d, cd;
    logic        de_q, de_d, tok;
    always_comb begin
        w   = 10'({r1_q, r2_q} >> offset_q);
        tok = w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
        cd  = {w == 10'h154 || w == 10'h2AB, w == 10'h0AB || w == 10'h2AB};
        q   = w[9] ? ~w[7:0] : w[7:0];
        d   = {q[7:1] ^ q[6:0] ^ {7{~w[8]}}, q[0]};
    end
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        dwell_d  = dwell_q;
        gap_d    = gap_q;
        offset_d = offset_q;
        if (state_q == SEARCH) begin
            run_d   = tok ? run_q + 8'd1 : 8'd0;
            dwell_d = dwell_q + 16'd1;
            // lock takes priority over a slip on the same cycle
            if (tok && run_q == 8'(TOKEN_RUN - 1)) begin
                state_d = LOCKED;
                run_d   = 8'd0;
                dwell_d = 16'd0;
                gap_d   = 16'd0;
            end else if (dwell_q == 16'(SEARCH_CYCLES - 1)) begin
                offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                run_d    = 8'd0;
                dwell_d  = 16'd0;
            end
        end else begin
            gap_d = tok ? 16'd0 : gap_q + 16'd1;
            if (!tok && gap_q == 16'(LOSS_CYCLES - 1)) begin
                state_d = SEARCH;
                run_d   = 8'd0;
                dwell_d = 16'd0;
                gap_d   = 16'd0;
            end
        end
        // outputs are gated by the current (pre-transition) state
        de_d   = state_q == LOCKED && !tok;
        ctrl_d = (state_q == LOCKED && tok) ? cd : 2'd0;
        data_d = de_d ? d : 8'd0;
    end
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            r1_q     <= '0;
            r2_q     <= '0;
            run_q    <= '0;
            dwell_q  <= '0;
            gap_q    <= '0;
            offset_q <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            r1_q     <= raw;
            r2_q     <= r1_q;
            run_q    <= run_d;
            dwell_q  <= dwell_d;
            gap_q    <= gap_d;
            offset_q <= offset_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
        end
    end
    assign data   = data_q;
    assign ctrl   = ctrl_q;
    assign de     = de_q;
    assign locked = state_q == LOCKED;
    assign offset = offset_q;
`ifdef TMDS_DEC_STATS_EN
    logic [15:0] err_q, err_d;
    always_comb
        err_d = (state_q == LOCKED && state_d == SEARCH && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    always_ff @(posedge clk_pix) begin
        if (!rst_n) err_q <= '0;
        else err_q <= err_d;
    end
    assign err_cnt = err_q;
`endif
endmodule
